// File: rtl/sine_meter_pkg.sv
// Shared types and constants for the two-channel sine period/phase meter.
package sine_meter_pkg;

    localparam int unsigned D_WIDTH_DEF = 8;
    localparam int unsigned C_WIDTH_DEF = 10;
    localparam int unsigned HYST_DEF    = 8;

    // Mid-scale of an unsigned offset-binary sample of the given width.
    function automatic int unsigned mid_of(input int unsigned width);
        return 32'd1 << (width - 32'd1);
    endfunction

    localparam int unsigned MID = mid_of(D_WIDTH_DEF);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_e;

endpackage

// File: rtl/zero_cross_det.sv
// Rising mid-scale crossing detector with hysteresis re-arm; cross_c is a
// same-cycle pulse for the sample currently presented on din.
module zero_cross_det
    import sine_meter_pkg::*;
#(
    parameter int unsigned D_WIDTH = D_WIDTH_DEF,
    parameter int unsigned HYST    = HYST_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [D_WIDTH-1:0] din,
    output logic               cross_c
);

    localparam int unsigned          MID_L   = mid_of(D_WIDTH);
    localparam logic [D_WIDTH-1:0]   MID_V   = D_WIDTH'(MID_L);
    localparam logic [D_WIDTH-1:0]   ARM_V   = D_WIDTH'(MID_L - HYST);

    logic armed_q;
    logic armed_d;

    // Firing uses the registered armed flag, so an arming sample never fires.
    always_comb begin
        armed_d = armed_q;
        cross_c = 1'b0;
        if (en) begin
            if (armed_q && (din >= MID_V)) begin
                cross_c = 1'b1;
                armed_d = 1'b0;
            end else if (din < ARM_V) begin
                armed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/sine_phase_meter.sv
// Measures ch1 period and ch1->ch2 lag, in en-samples, between rising
// mid-scale crossings; results are registered with a one-cycle valid pulse.
module sine_phase_meter
    import sine_meter_pkg::*;
#(
    parameter int unsigned D_WIDTH = D_WIDTH_DEF,
    parameter int unsigned C_WIDTH = C_WIDTH_DEF,
    parameter int unsigned HYST    = HYST_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [D_WIDTH-1:0] din1,
    input  logic [D_WIDTH-1:0] din2,
    output logic [C_WIDTH-1:0] period,
    output logic [C_WIDTH-1:0] lag,
    output logic               valid,
    output logic               locked
);

    localparam logic [C_WIDTH-1:0] CNT_MAX = '1;

    logic               cross1_c;
    logic               cross2_c;
    logic [C_WIDTH-1:0] idx_c;

    meter_state_e       state_q,    state_d;
    logic [C_WIDTH-1:0] cnt_q,      cnt_d;
    logic [C_WIDTH-1:0] lag_cap_q,  lag_cap_d;
    logic               lag_seen_q, lag_seen_d;
    logic [C_WIDTH-1:0] period_q,   period_d;
    logic [C_WIDTH-1:0] lag_q,      lag_d;
    logic               valid_q,    valid_d;
    logic               locked_q,   locked_d;

    zero_cross_det #(
        .D_WIDTH (D_WIDTH),
        .HYST    (HYST)
    ) u_det1 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .din     (din1),
        .cross_c (cross1_c)
    );

    zero_cross_det #(
        .D_WIDTH (D_WIDTH),
        .HYST    (HYST)
    ) u_det2 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .din     (din2),
        .cross_c (cross2_c)
    );

    // Index of the current sample within the window (crossing sample is 0).
    assign idx_c = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + C_WIDTH'(1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lag_cap_d  = lag_cap_q;
        lag_seen_d = lag_seen_q;
        period_d   = period_q;
        lag_d      = lag_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;

        if (en) begin
            case (state_q)
                IDLE: begin
                    if (cross1_c) begin
                        state_d    = MEASURE;
                        cnt_d      = '0;
                        lag_cap_d  = '0;
                        lag_seen_d = cross2_c;
                    end
                end
                MEASURE: begin
                    if (cross1_c) begin
                        if (lag_seen_q) begin
                            period_d = idx_c;
                            lag_d    = lag_cap_q;
                            valid_d  = 1'b1;
                            locked_d = 1'b1;
                        end else begin
                            locked_d = 1'b0;
                        end
                        // A coincident ch2 crossing opens the new window at lag 0.
                        cnt_d      = '0;
                        lag_cap_d  = '0;
                        lag_seen_d = cross2_c;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d    = IDLE;
                        locked_d   = 1'b0;
                        cnt_d      = '0;
                        lag_seen_d = 1'b0;
                    end else begin
                        cnt_d = idx_c;
                        if (cross2_c && !lag_seen_q) begin
                            lag_cap_d  = idx_c;
                            lag_seen_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lag_cap_q  <= '0;
            lag_seen_q <= 1'b0;
            period_q   <= '0;
            lag_q      <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lag_cap_q  <= lag_cap_d;
            lag_seen_q <= lag_seen_d;
            period_q   <= period_d;
            lag_q      <= lag_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
        end
    end

    assign period = period_q;
    assign lag    = lag_q;
    assign valid  = valid_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_sine_phase_meter.sv
// Scoreboard bench for sine_phase_meter: expected (sample, period, lag) entries
// are queued with the stimulus and checked whenever valid pulses.
module tb_sine_phase_meter;

    localparam int unsigned DW  = 8;
    localparam int unsigned CW  = 10;
    localparam int unsigned CW6 = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] din1;
    logic [DW-1:0] din2;

    logic [CW-1:0]  period;
    logic [CW-1:0]  lag;
    logic           valid;
    logic           locked;
    logic [CW6-1:0] period6;
    logic [CW6-1:0] lag6;
    logic           valid6;
    logic           locked6;

    always #5 clk = ~clk;

    sine_phase_meter #(.D_WIDTH(DW), .C_WIDTH(CW), .HYST(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .din1   (din1),
        .din2   (din2),
        .period (period),
        .lag    (lag),
        .valid  (valid),
        .locked (locked)
    );

    sine_phase_meter #(.D_WIDTH(DW), .C_WIDTH(CW6), .HYST(8)) dut6 (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .din1   (din1),
        .din2   (din2),
        .period (period6),
        .lag    (lag6),
        .valid  (valid6),
        .locked (locked6)
    );

    typedef struct {
        int t;
        int period;
        int lag;
    } exp_t;

    exp_t          sb_q[$];
    int            vcyc_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            tidx  = 0;
    int            cyc   = 0;
    logic [DW-1:0] rom [256];

    function automatic logic [DW-1:0] saw(input int t);
        int m;
        m = ((t % 32) + 32) % 32;
        return DW'(m * 8);
    endfunction

    task automatic push(input int t, input int p, input int l);
        exp_t x;
        x.t = t;
        x.period = p;
        x.lag = l;
        sb_q.push_back(x);
    endtask

    // One clock: present a sample (random junk when en=0), then score any valid.
    task automatic drive(input logic e, input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t x;
        en   = e;
        din1 = e ? a : DW'($urandom);
        din2 = e ? b : DW'($urandom);
        @(posedge clk);
        #1;
        cyc++;
        if (valid === 1'b1) begin
            vcyc_q.push_back(cyc);
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected_valid: valid=1 after sample %0d, required no valid", tidx);
            end else begin
                x = sb_q.pop_front();
                if (tidx !== x.t) begin
                    n_bad++;
                    $display("FAIL sb_valid_time: valid after sample %0d, required after %0d", tidx, x.t);
                end
                n_cmp++;
                if (period !== CW'(x.period)) begin
                    n_bad++;
                    $display("FAIL sb_period: got %0d, required %0d (sample %0d)", period, x.period, tidx);
                end
                n_cmp++;
                if (lag !== CW'(x.lag)) begin
                    n_bad++;
                    $display("FAIL sb_lag: got %0d, required %0d (sample %0d)", lag, x.lag, tidx);
                end
                n_cmp++;
                if (locked !== 1'b1) begin
                    n_bad++;
                    $display("FAIL sb_locked: got %b, required 1 (sample %0d)", locked, tidx);
                end
            end
        end
        if (e) tidx++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0);
        drive(1'b0, '0, '0);
        rst  = 1'b0;
        tidx = 0;
        sb_q.delete();
        vcyc_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 8'd0, 8'd0);
        drive(1'b1, 8'd200, 8'd200);
        rst = 1'b0;
        n_cmp++; if (period !== '0) begin n_bad++; $display("FAIL reset_period: got %0d, required 0", period); end
        n_cmp++; if (lag    !== '0) begin n_bad++; $display("FAIL reset_lag: got %0d, required 0", lag); end
        n_cmp++; if (valid  !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b, required 0", valid); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b, required 0", locked); end
    endtask

    task automatic test_sawtooth();
        do_reset();
        for (int k = 0; k < 4; k++) push(48 + 32 * k, 32, 5);
        for (int t = 0; t <= 150; t++) drive(1'b1, saw(t), saw(t - 5));
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL saw_locked: got %b, required 1", locked); end
        n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL saw_missing_valid: %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_sine(input logic toggle);
        do_reset();
        for (int k = 0; k < 4; k++) push(128 + 64 * k, 64, 48);
        for (int t = 0; t < 330; t++) begin
            drive(1'b1, rom[8'(4 * t)], rom[8'(4 * t + 64)]);
            if (toggle) drive(1'b0, '0, '0);
        end
        n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL sine_missing_valid: %0d pending, required 0 (toggle=%b)", sb_q.size(), toggle); end
        n_cmp++;
        if (vcyc_q.size() != 4) begin
            n_bad++;
            $display("FAIL sine_valid_count: got %0d, required 4 (toggle=%b)", vcyc_q.size(), toggle);
        end else begin
            for (int k = 1; k < 4; k++) begin
                n_cmp++;
                if (vcyc_q[k] - vcyc_q[k-1] != (toggle ? 128 : 64)) begin
                    n_bad++;
                    $display("FAIL sine_valid_spacing: got %0d clocks, required %0d", vcyc_q[k] - vcyc_q[k-1], toggle ? 128 : 64);
                end
            end
        end
    endtask

    task automatic test_ch2_lost();
        logic [DW-1:0] b;
        do_reset();
        push(48, 32, 5);
        push(144, 32, 5);
        push(176, 32, 5);
        for (int t = 0; t <= 176; t++) begin
            b = (t >= 49 && t < 112) ? 8'd0 : saw(t - 5);
            drive(1'b1, saw(t), b);
            if (t == 50) begin
                n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lost_locked_before: got %b, required 1", locked); end
            end
            if (t == 80 || t == 112) begin
                n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL lost_locked_drop: got %b, required 0 (sample %0d)", locked, t); end
                n_cmp++; if (period !== CW'(32)) begin n_bad++; $display("FAIL lost_period_hold: got %0d, required 32", period); end
            end
        end
        n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL lost_missing_valid: %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_timeout();
        logic [DW-1:0] a;
        do_reset();
        push(48, 32, 5);
        push(144, 96, 5);
        push(176, 32, 5);
        for (int t = 0; t <= 176; t++) begin
            a = (t <= 48 || t >= 113) ? saw(t) : 8'd200;
            drive(1'b1, a, saw(t - 5));
            if (t == 48) begin
                n_cmp++; if (valid6 !== 1'b1 || period6 !== CW6'(32) || lag6 !== CW6'(5)) begin
                    n_bad++; $display("FAIL to_first_lock: valid=%b period=%0d lag=%0d, required 1/32/5", valid6, period6, lag6); end
            end
            if (t == 111) begin
                n_cmp++; if (locked6 !== 1'b1) begin n_bad++; $display("FAIL to_before_timeout: locked=%b, required 1", locked6); end
            end
            if (t == 112) begin
                n_cmp++; if (locked6 !== 1'b0) begin n_bad++; $display("FAIL to_locked: got %b, required 0", locked6); end
                n_cmp++; if (period6 !== CW6'(32) || lag6 !== CW6'(5)) begin
                    n_bad++; $display("FAIL to_hold: period=%0d lag=%0d, required 32/5", period6, lag6); end
                n_cmp++; if (valid6 !== 1'b0) begin n_bad++; $display("FAIL to_valid: got %b, required 0", valid6); end
            end
            if (t == 144) begin
                n_cmp++; if (valid6 !== 1'b0) begin n_bad++; $display("FAIL to_idle_reentry: valid=%b, required 0", valid6); end
            end
            if (t == 176) begin
                n_cmp++; if (valid6 !== 1'b1 || period6 !== CW6'(32) || lag6 !== CW6'(5)) begin
                    n_bad++; $display("FAIL to_relock: valid=%b period=%0d lag=%0d, required 1/32/5", valid6, period6, lag6); end
            end
        end
        n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL to_missing_valid: %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_simul_reset();
        do_reset();
        push(48, 32, 0);
        push(80, 32, 0);
        for (int t = 0; t < 90; t++) drive(1'b1, saw(t), saw(t));
        n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL simul_missing_valid: %0d pending, required 0", sb_q.size()); end
        rst = 1'b1;
        drive(1'b1, saw(90), saw(90));
        rst = 1'b0;
        n_cmp++; if (period !== '0 || lag !== '0 || valid !== 1'b0 || locked !== 1'b0) begin
            n_bad++; $display("FAIL midreset_outputs: period=%0d lag=%0d valid=%b locked=%b, required all 0", period, lag, valid, locked); end
        push(144, 32, 0);
        for (int t = 91; t <= 150; t++) drive(1'b1, saw(t), saw(t));
        n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL midreset_missing_valid: %0d pending, required 0", sb_q.size()); end
    endtask

    initial begin
        real s;
        for (int i = 0; i < 256; i++) begin
            s = 127.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 256.0);
            rom[i] = DW'(128 + $rtoi($floor(s + 0.5)));
        end
        rst  = 1'b1;
        en   = 1'b0;
        din1 = '0;
        din2 = '0;

        test_reset();
        test_sawtooth();
        test_sine(1'b0);
        test_sine(1'b1);
        test_ch2_lost();
        test_timeout();
        test_simul_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sine_phase_meter.md
# sine_phase_meter

Measures a pair of 8-bit sample streams, such as the two outputs of the dual-port sine generator or two ADC/mic channels. For each cycle of channel 1 it reports:
- the period, in samples, between rising mid-scale crossings;
- the lag, in samples, from a channel-1 crossing to the next channel-2 crossing.

This is the analysis end of the signal-generation path. It recovers the step size and phase offset that a generator applies, and feeds results to the display/readout logic.

## Interface
Parameters:
- D_WIDTH, 8: sample width, unsigned offset-binary; mid-scale MID = 2^(D_WIDTH-1).
- C_WIDTH, 10: width of the sample counter and of the period/lag results.
- HYST, 8: hysteresis below MID required to re-arm a crossing detector.

Ports:
- clk  in  1  clock; the single clock domain.
- rst  in  1  synchronous, active-high reset.
- en  in  1  sample strobe; din1/din2 are sampled only on cycles with en=1.
- din1  in  D_WIDTH  channel-1 sample (reference channel).
- din2  in  D_WIDTH  channel-2 sample.
- period  out  C_WIDTH  last measured ch1 period, in en-samples.
- lag  out  C_WIDTH  last measured ch1→ch2 lag, in en-samples.
- valid  out  1  one-cycle pulse when period/lag update.
- locked  out  1  high while consecutive measurements succeed.

## Operation
Crossing detector, one per channel, evaluated only when en=1:
- armed is set when din < MID-HYST.
- A cross pulse is produced when armed=1 and din >= MID; armed clears on the same update.
- The sample that arms a detector cannot also fire it.
- armed resets to 0.

Sample counter cnt (C_WIDTH bits):
- cnt = 0 on a ch1-crossing sample.
- cnt increments by 1 on every other en sample while in MEASURE.

FSM states are IDLE and MEASURE.
- IDLE → MEASURE on a ch1 cross. Clear cnt and lag_seen.
- In MEASURE, on the first ch2 cross of the window, capture lag_cap = current sample index (the ch1-crossing sample is index 0) and set lag_seen. Later ch2 crosses in the same window are ignored.
- In MEASURE, on a ch1 cross at sample index N:
  - if lag_seen: period ← N, lag ← lag_cap, valid pulse, locked ← 1;
  - else: no update, locked ← 0.
  - In both cases, start a new window in the same cycle: cnt = 0, lag_seen cleared.
- Timeout: if cnt = 2^C_WIDTH-1 and the current sample is not a ch1 cross, go to IDLE with locked ← 0. period and lag hold.

Boundary rules:
- Simultaneous ch1 and ch2 crosses on one sample: the ch2 cross belongs to the new window, giving lag = 0 in that window.
- A ch2 cross while in IDLE is ignored.
- en=0 cycles are invisible: no state, counter or detector change.
- Reset mid-window discards the partial measurement.
- All arithmetic is unsigned and non-wrapping; cnt saturates only via the timeout rule.

## Timing
- Reset values: period=0, lag=0, valid=0, locked=0, state=IDLE, cnt=0, both detectors disarmed.
- All outputs are registered.
- valid asserts exactly one cycle, the cycle after the en cycle carrying the closing ch1 cross. period, lag and locked update in that same cycle.
- period and lag hold until the next valid.
- The minimum measurable period is 2; the first valid arrives no earlier than 2 ch1 crossings after reset.

## Structure
- Package sine_meter_pkg holds:
  - the state enum (IDLE, MEASURE);
  - localparam MID, derived from D_WIDTH;
  - the default HYST.
- Sub-module zero_cross_det contains the armed flag, the compare against MID/MID-HYST, and the cross output. It is instantiated once per channel.
- The top level contains the FSM, cnt, lag_cap/lag_seen and the output registers.

## Test plan
- Sawtooth on both channels, 0..248 in steps of 8, en every cycle, din2 = din1 delayed 5 samples → after 2 ch1 crossings: valid pulse, period=32, lag=5, locked=1; repeats every 32 samples.
- Sine ROM driven by an address step of 4, with ch2 address = ch1 address + 64 → period=64, lag=48, stable across 4 windows.
- Same stimulus with en toggling every other cycle → identical period/lag values; valid spacing is 2× in clock cycles.
- din2 held at 0 → no valid; locked stays 0; when din2 is restored, valid resumes on the second following ch1 crossing.
- din1 held at 200 after lock, with C_WIDTH=6 → timeout after cnt reaches 63, state IDLE, locked=0, period/lag unchanged.
- Identical din1=din2 sawtooth (simultaneous crossings) → lag=0 every window; rst asserted mid-window → all outputs 0 next cycle, and no valid until two fresh ch1 crossings.
